// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ / IDX_W : requester count and index width
//   arb_state_e   : FSM encoding (IDLE=0, GRANT=1)
//   idx_inc       : 3-bit wrapping increment used for the priority pointer
package rr_arbiter_8_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
//   en        : global enable
//   req       : request lines, bit i = requester i
//   gnt_sel   : encoded index of the grant holder
//   gnt_valid : a grant is active
//   gnt       : one-hot grant, zero while en is low
//   timeout   : one-cycle pulse on a forced release
interface rr_arbiter_8_if;
  import rr_arbiter_8_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] gnt_sel;
  logic             gnt_valid;
  logic [N_REQ-1:0] gnt;
  logic             timeout;

  modport master (output en, req, input gnt_sel, gnt_valid, gnt, timeout);
  modport slave  (input en, req, output gnt_sel, gnt_valid, gnt, timeout);
endinterface

// File: rtl/dec3to8.sv
// Existing 3-to-8 decoder with gate input.
//   g   : gate; output is all-zero when low
//   sel : index to decode
//   y   : one-hot output
module dec3to8 (
  input  logic       g,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = g ? (8'h01 << sel) : 8'h00;
endmodule

// File: rtl/rr_arbiter_8_pick.sv
// rr_pick8: combinational round-robin winner search.
//   req : request lines
//   ptr : highest-priority index; search runs ptr, ptr+1, ... modulo 8
//   idx : winning index (meaningful only when any=1)
//   any : at least one request is set
// Rotate so ptr lands on bit 0, take the lowest set bit, then add ptr back.
module rr_pick8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ptr + IDX_W'(i)];
    end
  end

  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters sharing one decoded resource.
// A grant is held while the winner keeps its request high; each release moves the
// priority pointer to holder+1 and forces one idle cycle before the next grant.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : rr_arbiter_8_if.slave (en, req in; gnt_sel, gnt_valid, gnt, timeout out)
//   HOLD_MAX : grant cycles before a forced release (ARB_TIMEOUT_EN only), 1..2^CW-1
//   CW       : hold counter width
// Optional feature macro: ARB_TIMEOUT_EN (hold counter + timeout pulse). Without it
// grants are unbounded and timeout is tied low.
//
// state | meaning
// IDLE  | no grant; arbitrate when en=1 and any request is set
// GRANT | gnt_sel owns the resource until its request drops (or hold limit)
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] gnt_sel_q, gnt_sel_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             win;
  logic             release_w;
  logic             force_rel;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign win = (state_q == IDLE) && bus.en && pick_any;
  // Release detection ignores en so a holder can let go while the grant is masked.
  assign release_w = (state_q == GRANT) && (!bus.req[gnt_sel_q] || force_rel);

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q, timeout_d;

  assign force_rel = (state_q == GRANT) && bus.req[gnt_sel_q] &&
                     (hold_cnt_q == CW'(HOLD_MAX - 1));
  assign timeout_d = force_rel;

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (win) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg  = (HOLD_MAX > 0) ^ (CW > 0);
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (win)       state_d = GRANT;
      GRANT: if (release_w) state_d = IDLE;
    endcase
  end

  // Output / pointer next values
  always_comb begin
    gnt_sel_d   = gnt_sel_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    if (win) begin
      gnt_sel_d   = pick_idx;
      gnt_valid_d = 1'b1;
    end else if (release_w) begin
      gnt_valid_d = 1'b0;
      ptr_d       = idx_inc(gnt_sel_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_sel_q   <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      gnt_sel_q   <= gnt_sel_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.gnt_sel   = gnt_sel_q;
  assign bus.gnt_valid = gnt_valid_q;

  dec3to8 u_dec (
    .g   (bus.en & gnt_valid_q),
    .sel (gnt_sel_q),
    .y   (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: vector table, directed multi-cycle sequences and a
// randomized run against a reference model built from the arbitration rules.
module tb_rr_arbiter_8;

  localparam int TB_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_8_if bus();

  rr_arbiter_8 #(.HOLD_MAX(TB_HOLD), .CW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  bit m_valid;
  int m_sel;
  int m_ptr;
  int m_held;
  bit m_to;

  typedef struct {
    logic       en;
    logic [7:0] req;
    logic [2:0] e_sel;
    logic       e_v;
    logic [7:0] e_gnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] e_sel, input logic e_v,
                          input logic [7:0] e_gnt);
    check({tag, ".sel"},   32'(bus.gnt_sel),   32'(e_sel));
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(e_v));
    check({tag, ".gnt"},   32'(bus.gnt),       32'(e_gnt));
  endtask

  task automatic chk_to(input string tag, input logic e_to);
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(e_to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    bus.en  = 1'b0;
    bus.req = 8'h00;
    rst_n   = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    chk_outs(tag, 3'd0, 1'b0, 8'h00);
    chk_to(tag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the arbitration rules, given the inputs sampled at that edge.
  task automatic model_edge(input logic en_s, input logic [7:0] req_s);
    bit found;
    m_to = 1'b0;
    if (m_valid) begin
      if (!req_s[m_sel]) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 8;
      end else if (TO_EN && m_held == TB_HOLD) begin
        m_valid = 1'b0;
        m_ptr   = (m_sel + 1) % 8;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else if (en_s && req_s != 8'h00) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!found && req_s[(m_ptr + k) % 8]) begin
          m_sel = (m_ptr + k) % 8;
          found = 1'b1;
        end
      end
      m_valid = 1'b1;
      m_held  = 1;
    end
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] e_gnt;
    e_gnt = (bus.en && m_valid) ? (8'h01 << m_sel) : 8'h00;
    chk_outs(tag, 3'(m_sel), m_valid, e_gnt);
    chk_to(tag, m_to);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic       e;

    // en, req -> expected sel, valid, gnt after the edge
    vecs[0]  = '{1'b1, 8'h01, 3'd0, 1'b1, 8'h01};
    vecs[1]  = '{1'b1, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'h10, 3'd4, 1'b1, 8'h10};
    vecs[3]  = '{1'b1, 8'h00, 3'd4, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'h09, 3'd0, 1'b1, 8'h01};
    vecs[5]  = '{1'b1, 8'h08, 3'd0, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h08, 3'd3, 1'b1, 8'h08};
    vecs[7]  = '{1'b1, 8'h08, 3'd3, 1'b1, 8'h08};
    vecs[8]  = '{1'b1, 8'hFF, 3'd3, 1'b1, 8'h08};
    vecs[9]  = '{1'b0, 8'hFF, 3'd3, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 8'hF7, 3'd3, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 8'hF7, 3'd3, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 8'hF7, 3'd4, 1'b1, 8'h10};
    vecs[13] = '{1'b1, 8'h00, 3'd4, 1'b0, 8'h00};

    do_reset("reset0");
    for (int i = 0; i < 14; i++) begin
      bus.en  = vecs[i].en;
      bus.req = vecs[i].req;
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_v, vecs[i].e_gnt);
    end

    // Full rotation: every requester holds 2 cycles, one empty cycle between grants.
    do_reset("reset_rr");
    bus.en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      int w;
      w = k % 8;
      bus.req = 8'hFF;
      tick();
      chk_outs($sformatf("rr%0d_a", k), 3'(w), 1'b1, 8'h01 << w);
      tick();
      chk_outs($sformatf("rr%0d_b", k), 3'(w), 1'b1, 8'h01 << w);
      bus.req = 8'hFF & ~(8'h01 << w);
      tick();
      chk_outs($sformatf("rr%0d_gap", k), 3'(w), 1'b0, 8'h00);
    end

    // Enable dropped mid-grant.
    do_reset("reset_en");
    bus.en  = 1'b1;
    bus.req = 8'h04;
    tick();
    chk_outs("en_grant", 3'd2, 1'b1, 8'h04);
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_outs($sformatf("en_low%0d", k), 3'd2, 1'b1, 8'h00);
    end
    bus.en = 1'b1;
    #1;
    chk_outs("en_back", 3'd2, 1'b1, 8'h04);
    bus.req = 8'h00;
    tick();
    chk_outs("en_rel", 3'd2, 1'b0, 8'h00);
    chk_to("en_rel", 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset("reset_mid0");
    bus.en  = 1'b1;
    bus.req = 8'h20;
    tick();
    chk_outs("mid_g5", 3'd5, 1'b1, 8'h20);
    bus.req = 8'h00;
    tick();
    bus.req = 8'h40;
    tick();
    chk_outs("mid_g6", 3'd6, 1'b1, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst", 3'd0, 1'b0, 8'h00);
    chk_to("mid_rst", 1'b0);
    bus.req = 8'hFF;
    #3;
    rst_n = 1'b1;
    tick();
    chk_outs("mid_after", 3'd0, 1'b1, 8'h01);

    // Long hold by requester 6 with 7 waiting.
    do_reset("reset_to");
    bus.en  = 1'b1;
    bus.req = 8'hC0;
    for (int c = 1; c <= TB_HOLD + 2; c++) begin
      tick();
      if (!TO_EN || c <= TB_HOLD) begin
        chk_outs($sformatf("hold%0d", c), 3'd6, 1'b1, 8'h40);
        chk_to($sformatf("hold%0d", c), 1'b0);
      end else if (c == TB_HOLD + 1) begin
        chk_outs($sformatf("hold%0d", c), 3'd6, 1'b0, 8'h00);
        chk_to($sformatf("hold%0d", c), 1'b1);
      end else begin
        chk_outs($sformatf("hold%0d", c), 3'd7, 1'b1, 8'h80);
        chk_to($sformatf("hold%0d", c), 1'b0);
      end
    end

    // Randomized run against the reference model.
    do_reset("reset_rand");
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      r = 8'($urandom);
      if (m_valid && $urandom_range(0, 3) != 0) r[m_sel] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = 8'h00;
      e = ($urandom_range(0, 7) != 0);
      bus.en  = e;
      bus.req = r;
      tick();
      model_edge(e, r);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one 8-way decoded resource (bus, display digit, memory bank) among 8 requesters.
- Produces an encoded 3-bit grant index plus a one-hot grant vector. The one-hot vector is generated through the team's existing 3-to-8 decoder, with G = EN & GNT_VALID.
- A grant is held for as long as the winner keeps its request high. Fairness comes from a rotating priority pointer.

Parameters:
- HOLD_MAX, 15, maximum consecutive grant cycles before forced release. Used only with ARB_TIMEOUT_EN; range 1..2^CW-1.
- CW, 4, width of the hold counter.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- EN  input  1  global enable. When low, GNT is forced to 0 and no new arbitration starts.
- REQ  input  8  request lines; bit i belongs to requester i.
- GNT_SEL  output  3  index of the current grant holder (registered).
- GNT_VALID  output  1  a grant is active (registered).
- GNT  output  8  one-hot grant = decode(GNT_SEL) when EN & GNT_VALID, else 8'h00.
- TIMEOUT  output  1  one-cycle pulse on a forced release. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, GNT_SEL=0, GNT_VALID=0, GNT=0, TIMEOUT=0, PTR=0, hold counter=0.
- State encoding: IDLE=1'b0, GRANT=1'b1.
- PTR (3-bit) is the highest-priority index. Search order is PTR, PTR+1, …, wrapping modulo 8.
- IDLE, when EN=1 and REQ≠0:
  - Winner is the first set bit in search order.
  - Next edge: GNT_SEL=winner, GNT_VALID=1, state→GRANT. Latency is one cycle from REQ sampled to GNT.
- IDLE, when EN=0 or REQ=0: remain in IDLE; outputs unchanged (GNT_VALID=0).
- GRANT, REQ[GNT_SEL]=1: hold the grant. Other requests are ignored.
- GRANT, REQ[GNT_SEL]=0 (release):
  - Next edge: GNT_VALID=0, PTR=GNT_SEL+1 (3-bit wrap, 7→0), state→IDLE.
  - GNT_SEL keeps its last value.
- One mandatory idle cycle follows every release, so back-to-back grants are separated by exactly one cycle with GNT=0.
- EN dropped while in GRANT:
  - GNT goes to 0 combinationally.
  - State, GNT_SEL and PTR hold.
  - Release detection continues. If REQ[GNT_SEL] falls while EN=0, the normal release occurs.
- EN re-raised while still in GRANT: GNT reappears for the same holder with no re-arbitration.
- Simultaneous release and a new request from another requester: the release is processed first. The new request is arbitrated in the following IDLE cycle using the updated PTR.
- Requester i re-requesting immediately after its own release: it has the lowest priority on the next arbitration.
- RST_N asserted mid-grant: all outputs clear immediately. After reset release, arbitration restarts from PTR=0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A CW-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches HOLD_MAX-1 while REQ[GNT_SEL] is still 1, a forced release occurs: same transitions as a normal release, plus TIMEOUT=1 for exactly one cycle (the cycle GNT_VALID drops).
  - The held requester must drop and re-raise REQ to compete again. A still-high REQ is simply re-arbitrated from IDLE, behind the others via PTR.
- Without the macro: no counter is built, TIMEOUT is constant 0, and grants are unbounded.

Decomposition:
- Shared include/package arb_defs: N_REQ=8, IDX_W=3, state encodings IDLE/GRANT.
- Sub-module rr_pick8 (combinational): inputs REQ[7:0], PTR[2:0]; outputs IDX[2:0] and ANY. Implemented as rotate, priority-encode, un-rotate.
- The FSM, PTR, hold counter and output registers stay in the top module.
- GNT is produced by instantiating the existing 3-to-8 decoder (G=EN&GNT_VALID, SEL=GNT_SEL).

Test Plan:
- Reset, EN=1, REQ=8'h01 → after 1 edge GNT_SEL=0, GNT=8'h01. REQ→0 → next edge GNT=0, PTR=1.
- PTR=0, REQ=8'hFF held, each winner drops its REQ after 2 cycles → grant order 0,1,…,7,0, with exactly one GNT=0 cycle between grants.
- PTR=5 (after a grant to 4), REQ=8'h09 → winner 0. Then REQ=8'h08 → winner 3 (wrap check).
- Grant to 2 active, EN=0 for 3 cycles → GNT=0 while GNT_SEL=2 and GNT_VALID=1 hold. EN=1 → GNT=8'h04 again.
- RST_N pulsed low mid-grant (not clock-aligned) → GNT, GNT_VALID and TIMEOUT go 0 immediately; first grant after reset follows PTR=0.
- ARB_TIMEOUT_EN, HOLD_MAX=4, REQ[6] held high → GNT=8'h40 for exactly 4 cycles, then TIMEOUT=1 for one cycle and PTR=7. REQ[7] waiting is granted next.
